// File: rtl/mac_pkg.sv
// Shared types and constants for the product accumulator that follows the 3-bit array multiplier.
package mac_pkg;

  localparam int PRODUCT_W   = 6;
  localparam int MAX_PRODUCT = 49;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } mac_state_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator adder: acc plus zero-extended product, with carry-out.
// MAC_ACC_SATURATE_EN clamps the sum at all-ones whenever the add carries.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int AW = 8,
  parameter int PW = PRODUCT_W
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] p,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] raw;

  assign raw   = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, p};
  assign carry = raw[AW];

`ifdef MAC_ACC_SATURATE_EN
  // acc only grows within a group, so a clamped acc stays clamped.
  assign sum = carry ? {AW{1'b1}} : raw[AW-1:0];
`else
  assign sum = raw[AW-1:0];
`endif

endmodule

// File: rtl/mac_product_accumulator.sv
// Sums each group of COUNT accepted products and presents the sum with an overflow flag.
// Optional clamping arithmetic is selected with MAC_ACC_SATURATE_EN.
module mac_product_accumulator
  import mac_pkg::*;
#(
  parameter int PW    = PRODUCT_W,
  parameter int COUNT = 8,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf
);

  localparam int CNT_W = clog2(COUNT + 1);

  // FSM state and beat count kept together so both are visible as one signal.
  typedef struct packed {
    mac_state_t       state;
    logic [CNT_W-1:0] cnt;
  } mac_ctl_t;

  mac_ctl_t      ctl;
  logic [AW-1:0] acc;
  logic          ovf_sticky;
  logic [AW-1:0] add_sum;
  logic          add_carry;
  logic          accept;
  logic          last_beat;

  mac_sat_add #(
    .AW(AW),
    .PW(PW)
  ) u_add (
    .acc  (acc),
    .p    (in_p),
    .sum  (add_sum),
    .carry(add_carry)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready; valid,
  // once raised, holds with stable data until that transfer. in_ready may depend
  // combinationally on out_ready so a held result and a new beat swap in one cycle.
  assign in_ready  = rst_n && !clear && (ctl.state == ACC || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (ctl.cnt == CNT_W'(COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl.state  <= ACC;
      ctl.cnt    <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
    end else if (clear) begin
      ctl.state  <= ACC;
      ctl.cnt    <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (ctl.state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        ctl.state <= ACC;
      end
      // In HOLD acc/cnt are already zero, so a beat taken alongside the
      // consumed result simply opens the next group (or closes it if COUNT==1).
      if (accept) begin
        if (last_beat) begin
          out_sum    <= add_sum;
          out_ovf    <= ovf_sticky | add_carry;
          out_valid  <= 1'b1;
          acc        <= '0;
          ctl.cnt    <= '0;
          ovf_sticky <= 1'b0;
          ctl.state  <= HOLD;
        end else begin
          acc        <= add_sum;
          ctl.cnt    <= ctl.cnt + CNT_W'(1);
          ovf_sticky <= ovf_sticky | add_carry;
        end
      end
    end
  end

endmodule
